// File: rtl/bram_axil_ctrl_if.sv
// AXI-Lite slave bus bundle for bram_axil_ctrl; the master drives requests, the slave answers.
interface bram_axil_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/bram_axil_ctrl.sv
// AXI-Lite slave to single-port BRAM bridge, one transaction at a time.
// Define BRAM_CTRL_RANGE_CHK_EN to reject word indices >= NUM_WORDS with SLVERR.
module bram_axil_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_WORDS  = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  bram_axil_ctrl_if.slave       s,
  output logic [3:0]            bram_we,
  output logic                  bram_en,
  output logic [31:0]           bram_di,
  output logic [ADDR_WIDTH-1:0] bram_a,
  input  logic [31:0]           bram_do
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD0, RD1, RRESP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic                  wr_go, rd_go;
  logic                  aw_err, ar_err;

  if (NUM_WORDS < 1 || NUM_WORDS > (1 << (ADDR_WIDTH - 2))) begin : g_bad_cfg
    $error("NUM_WORDS does not fit the ADDR_WIDTH word-index space");
  end

`ifdef BRAM_CTRL_RANGE_CHK_EN
  localparam logic [31:0] NW = NUM_WORDS;
  assign aw_err = 32'(s.awaddr[ADDR_WIDTH-1:2]) >= NW;
  assign ar_err = 32'(s.araddr[ADDR_WIDTH-1:2]) >= NW;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Write wins a simultaneous request; read only accepted when no full write request is present.
  assign wr_go = !RST && (state == IDLE) && s.awvalid && s.wvalid;
  assign rd_go = !RST && (state == IDLE) && s.arvalid && !(s.awvalid && s.wvalid);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (wr_go) begin
        addr_q  <= s.awaddr;
        wdata_q <= s.wdata;
        wstrb_q <= s.wstrb;
        err_q   <= aw_err;
      end else if (rd_go) begin
        addr_q <= s.araddr;
        err_q  <= ar_err;
      end
      if (state == RD1) rdata_q <= err_q ? '0 : bram_do;
    end
  end

  always_comb begin
    state_nxt = state;
    s.awready = 1'b0;
    s.wready  = 1'b0;
    s.arready = 1'b0;
    s.bvalid  = 1'b0;
    s.rvalid  = 1'b0;
    bram_en   = 1'b0;
    bram_we   = '0;
    unique case (state)
      IDLE: begin
        if (wr_go) begin
          s.awready = 1'b1;
          s.wready  = 1'b1;
          state_nxt = WR;
        end else if (rd_go) begin
          s.arready = 1'b1;
          state_nxt = RD0;
        end
      end
      WR: begin
        bram_en   = !err_q;
        bram_we   = err_q ? '0 : wstrb_q;
        state_nxt = WRESP;
      end
      WRESP: begin
        s.bvalid = 1'b1;
        if (s.bready) state_nxt = IDLE;
      end
      RD0: begin
        bram_en   = !err_q;
        state_nxt = RD1;
      end
      RD1: begin
        bram_en   = !err_q;
        state_nxt = RRESP;
      end
      RRESP: begin
        s.rvalid = 1'b1;
        if (s.rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bram_a  = addr_q;
  assign bram_di = wdata_q;
  assign s.rdata = rdata_q;
  assign s.bresp = {err_q, 1'b0};
  assign s.rresp = {err_q, 1'b0};

endmodule

// File: tb/tb_bram_axil_ctrl.sv
// Scoreboard bench for bram_axil_ctrl with a behavioural 1-cycle-latency BRAM.
// Build with BRAM_CTRL_RANGE_CHK_EN defined to also exercise out-of-range handling.
module tb_bram_axil_ctrl;
  localparam int AW = 12;
  localparam int NW = 12;
`ifdef BRAM_CTRL_RANGE_CHK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [3:0]    bram_we;
  logic          bram_en;
  logic [31:0]   bram_di;
  logic [31:0]   bram_do;
  logic [AW-1:0] bram_a;
  logic [31:0]   mem    [16];
  logic [31:0]   shadow [16];
  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 CLK = ~CLK;

  bram_axil_ctrl_if #(.ADDR_WIDTH(AW)) axi ();

  bram_axil_ctrl #(.ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .s       (axi),
    .bram_we (bram_we),
    .bram_en (bram_en),
    .bram_di (bram_di),
    .bram_a  (bram_a),
    .bram_do (bram_do)
  );

  always @(posedge CLK) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_a[5:2]][b*8 +: 8] <= bram_di[b*8 +: 8];
      bram_do <= mem[bram_a[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Responses are matched against the queue at the negedge before their handshake edge.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && axi.bvalid && axi.bready) begin
      if (sb.size() == 0) check("sb_b_unexpected", 32'(axi.bvalid), 32'd0);
      else begin
        e = sb.pop_front();
        check("sb_b_kind", 32'(e.is_rd), 32'd0);
        check("sb_bresp", 32'(axi.bresp), 32'(e.resp));
      end
    end
    if (!RST && axi.rvalid && axi.rready) begin
      if (sb.size() == 0) check("sb_r_unexpected", 32'(axi.rvalid), 32'd0);
      else begin
        e = sb.pop_front();
        check("sb_r_kind", 32'(e.is_rd), 32'd1);
        check("sb_rdata", axi.rdata, e.data);
        check("sb_rresp", 32'(axi.rresp), 32'(e.resp));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit is_oor(input logic [AW-1:0] addr);
    return RANGE_ON && (32'(addr[AW-1:2]) >= NW);
  endfunction

  task automatic wait_b();
    int n = 0;
    while (!(axi.bvalid && axi.bready) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check("b_timeout", 32'(n), 32'd0);
    tick();
  endtask

  task automatic wait_r();
    int n = 0;
    while (!(axi.rvalid && axi.rready) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check("r_timeout", 32'(n), 32'd0);
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold);
    exp_t e;
    bit   oor = is_oor(addr);
    if (!oor)
      for (int b = 0; b < 4; b++)
        if (strb[b]) shadow[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
    e.is_rd = 1'b0;
    e.data  = '0;
    e.resp  = oor ? 2'b10 : 2'b00;
    sb.push_back(e);
    if (hold > 0) axi.bready = 1'b0;
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    @(negedge CLK);
    check("wr_awready", 32'(axi.awready), 32'd1);
    check("wr_wready", 32'(axi.wready), 32'd1);
    check("wr_arready", 32'(axi.arready), 32'd0);
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    @(negedge CLK);
    check("wr_en", 32'(bram_en), oor ? 32'd0 : 32'd1);
    check("wr_we", 32'(bram_we), 32'(oor ? 4'h0 : strb));
    check("wr_a", 32'(bram_a), 32'(addr));
    if (!oor) check("wr_di", bram_di, data);
    tick();
    @(negedge CLK);
    check("wr_bvalid", 32'(axi.bvalid), 32'd1);
    check("wr_bram_we_idle", 32'(bram_we), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      axi.arvalid = 1'b1;
      axi.araddr  = '0;
      @(negedge CLK);
      check("b_hold_valid", 32'(axi.bvalid), 32'd1);
      check("b_hold_resp", 32'(axi.bresp), 32'(e.resp));
      check("b_hold_arready", 32'(axi.arready), 32'd0);
    end
    if (hold > 0) begin
      tick();
      axi.arvalid = 1'b0;
      axi.bready  = 1'b1;
      @(negedge CLK);
    end
    wait_b();
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int hold);
    exp_t e;
    bit   oor = is_oor(addr);
    e.is_rd = 1'b1;
    e.data  = oor ? 32'd0 : shadow[addr[5:2]];
    e.resp  = oor ? 2'b10 : 2'b00;
    sb.push_back(e);
    if (hold > 0) axi.rready = 1'b0;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    @(negedge CLK);
    check("rd_arready", 32'(axi.arready), 32'd1);
    check("rd_awready", 32'(axi.awready), 32'd0);
    tick();
    axi.arvalid = 1'b0;
    @(negedge CLK);
    check("rd0_en", 32'(bram_en), oor ? 32'd0 : 32'd1);
    check("rd0_we", 32'(bram_we), 32'd0);
    check("rd0_a", 32'(bram_a), 32'(addr));
    tick();
    @(negedge CLK);
    check("rd1_en", 32'(bram_en), oor ? 32'd0 : 32'd1);
    check("rd1_a", 32'(bram_a), 32'(addr));
    tick();
    @(negedge CLK);
    check("rd_rvalid", 32'(axi.rvalid), 32'd1);
    check("rrsp_en", 32'(bram_en), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      @(negedge CLK);
      check("r_hold_valid", 32'(axi.rvalid), 32'd1);
      check("r_hold_data", axi.rdata, e.data);
    end
    if (hold > 0) begin
      tick();
      axi.rready = 1'b1;
      @(negedge CLK);
    end
    wait_r();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(axi.awready), 32'd0);
    check({tag, "_arready"}, 32'(axi.arready), 32'd0);
    check({tag, "_bvalid"}, 32'(axi.bvalid), 32'd0);
    check({tag, "_rvalid"}, 32'(axi.rvalid), 32'd0);
    check({tag, "_en"}, 32'(bram_en), 32'd0);
    check({tag, "_we"}, 32'(bram_we), 32'd0);
    check({tag, "_a"}, 32'(bram_a), 32'd0);
    check({tag, "_di"}, bram_di, 32'd0);
    check({tag, "_rdata"}, axi.rdata, 32'd0);
    check({tag, "_resp"}, 32'({axi.bresp, axi.rresp}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    RST         = 1'b1;
    axi.awaddr  = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b1;
    axi.araddr  = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst");
    tick();
    RST = 1'b0;

    for (int w = 0; w < NW; w++) do_write(AW'(w * 4), $urandom, 4'hF, 0);
    for (int w = 0; w < NW; w++) do_read(AW'(w * 4), 0);

    do_write(12'h008, 32'hDEADBEEF, 4'hF, 0);
    do_read(12'h008, 0);

    do_write(12'h004, 32'hFFFFFFFF, 4'hF, 0);
    do_write(12'h004, 32'h11223344, 4'b0101, 0);
    do_read(12'h004, 0);

    do_write(12'h00C, 32'h0BADF00D, 4'b0000, 0);
    do_read(12'h00C, 0);

    axi.araddr  = 12'h008;
    axi.arvalid = 1'b1;
    do_write(12'h010, 32'hA5A55A5A, 4'hF, 0);
    do_read(12'h008, 0);
    do_read(12'h010, 0);

    do_read(12'h004, 5);
    do_write(12'h02C, 32'h13579BDF, 4'b1010, 4);
    do_read(12'h02C, 0);

    for (int i = 0; i < 20; i++) begin
      a = AW'($urandom_range(0, NW - 1) * 4);
      do_write(a, $urandom, 4'($urandom_range(0, 15)), 0);
      do_read(AW'($urandom_range(0, NW - 1) * 4), 0);
    end

`ifdef BRAM_CTRL_RANGE_CHK_EN
    do_write(12'h030, 32'hCAFEF00D, 4'hF, 0);
    do_read(12'h030, 0);
    do_read(12'h02C, 0);
`endif

    // Reset pulse during RD1: the read must vanish without a response.
    axi.araddr  = 12'h008;
    axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    tick();
    @(negedge CLK);
    check("rst_rd1_en", 32'(bram_en), 32'd1);
    #2 RST = 1'b1;
    #1 check_reset_outputs("rst_rd");
    #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("rst_rd_no_rvalid", 32'(axi.rvalid), 32'd0);
    end
    tick();

    // Reset pulse during WR: no write response afterwards.
    axi.awaddr  = 12'h014;
    axi.wdata   = 32'h12345678;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    @(negedge CLK);
    check("rst_wr_we", 32'(bram_we), 32'hF);
    #2 RST = 1'b1;
    #1 check_reset_outputs("rst_wr");
    #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("rst_wr_no_bvalid", 32'(axi.bvalid), 32'd0);
    end
    tick();
    do_read(12'h008, 0);

    repeat (3) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
